// File: rtl/alu_seq_pkg.sv
// Shared types for the ALU stall sequencer: FSM state enum, ALU opcodes,
// and the multi-cycle opcode classifier.
package alu_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_COMMIT = 2'd2,
    ST_FAULT  = 2'd3
  } state_e;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0010;
  localparam logic [3:0] OP_OR  = 4'b0011;
  localparam logic [3:0] OP_SLT = 4'b0100;
  localparam logic [3:0] OP_MUL = 4'b0101;
  localparam logic [3:0] OP_DIV = 4'b0110;
  localparam logic [3:0] OP_MOD = 4'b0111;

  // MUL/DIV/MOD run on the iterative ALU and need the stall handshake
  function automatic logic is_multicycle(input logic [3:0] op);
    return (op == OP_MUL) || (op == OP_DIV) || (op == OP_MOD);
  endfunction

endpackage

// File: rtl/alu_stall_sequencer_if.sv
// Decoder/ALU-side bundle of the stall sequencer. master = decoder/ALU side,
// slave = the sequencer itself.
interface alu_stall_sequencer_if #(parameter int CNT_W = 8);
  logic [3:0]       ALUControl;
  logic             RegWriteIn;
  logic             MemWriteIn;
  logic             PCSrcIn;
  logic             Finished;
  logic             StartALU;
  logic             PCWrite;
  logic             RegWrite;
  logic             MemWrite;
  logic             PCSrc;
  logic             Stall;
  logic             Timeout;
  logic [CNT_W-1:0] BusyCycles;

  modport master (
    output ALUControl, RegWriteIn, MemWriteIn, PCSrcIn, Finished,
    input  StartALU, PCWrite, RegWrite, MemWrite, PCSrc, Stall, Timeout, BusyCycles
  );

  modport slave (
    input  ALUControl, RegWriteIn, MemWriteIn, PCSrcIn, Finished,
    output StartALU, PCWrite, RegWrite, MemWrite, PCSrc, Stall, Timeout, BusyCycles
  );
endinterface

// File: rtl/alu_stall_sequencer_cycle_counter.sv
// Saturating up-counter with synchronous clear (priority) and enable.
// o_cnt_inc is the saturated value the counter would take on an enabled cycle.
module cycle_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             i_clr,
  input  logic             i_en,
  output logic [CNT_W-1:0] o_cnt_inc
);
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_inc;

  // hold at all-ones instead of wrapping
  always_comb begin
    w_inc = (r_cnt == {CNT_W{1'b1}}) ? r_cnt : r_cnt + 1'b1;
  end

  // clear wins over count
  always_ff @(posedge clk) begin
    if (i_clr)     r_cnt <= '0;
    else if (i_en) r_cnt <= w_inc;
  end

  assign o_cnt_inc = w_inc;
endmodule

// File: rtl/alu_stall_sequencer.sv
// Stall sequencer for multi-cycle ALU ops: issues StartALU, freezes PC and
// architectural writes while the ALU works, then commits in one cycle.
// Optional watchdog: define ALU_STALL_TIMEOUT_EN to enable the FAULT state.
module alu_stall_sequencer
  import alu_seq_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  alu_stall_sequencer_if.slave  bus
);
  localparam logic [1:0] S_IDLE   = ST_IDLE;
  localparam logic [1:0] S_WAIT   = ST_WAIT;
  localparam logic [1:0] S_COMMIT = ST_COMMIT;
`ifdef ALU_STALL_TIMEOUT_EN
  localparam logic [1:0] S_FAULT  = ST_FAULT;
  localparam logic [CNT_W-1:0] TMO_LIM = CNT_W'(TIMEOUT_CYCLES);
`endif

  // the watchdog limit must fit in the counter
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > (2**CNT_W) - 1) begin : g_bad_cfg
    $error("TIMEOUT_CYCLES does not fit in CNT_W bits");
  end

  logic [1:0]       r_state;
  logic [1:0]       w_nxt;
  logic [CNT_W-1:0] r_busy;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             w_mc;
  logic             w_issue;
  logic             w_start, w_pcw, w_rw, w_mw, w_pcs, w_stall, w_tmo;

  assign w_mc    = is_multicycle(bus.ALUControl);
  assign w_issue = (r_state == S_IDLE) && w_mc;

  // counts WAIT cycles; cleared on issue so each op starts from zero
  cycle_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk       (clk),
    .i_clr     (reset || w_issue),
    .i_en      (r_state == S_WAIT),
    .o_cnt_inc (w_cnt_inc)
  );

  // next-state: Finished has priority over the watchdog in WAIT
  always_comb begin
    w_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_mc) w_nxt = S_WAIT;
      S_WAIT: begin
        if (bus.Finished) w_nxt = S_COMMIT;
`ifdef ALU_STALL_TIMEOUT_EN
        else if (w_cnt_inc == TMO_LIM) w_nxt = S_FAULT;
`endif
      end
      S_COMMIT: w_nxt = S_IDLE;
`ifdef ALU_STALL_TIMEOUT_EN
      S_FAULT:  w_nxt = S_FAULT;
`endif
      default:  w_nxt = S_IDLE;
    endcase
  end

  // state register; reset aborts any op in flight without a commit
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_nxt;
  end

  // latch WAIT length (including the Finished cycle) of the completed op
  always_ff @(posedge clk) begin
    if (reset)                              r_busy <= '0;
    else if (r_state == S_WAIT && bus.Finished) r_busy <= w_cnt_inc;
  end

  // output gating; everything is forced low while reset is asserted
  always_comb begin
    w_start = 1'b0;
    w_pcw   = 1'b0;
    w_rw    = 1'b0;
    w_mw    = 1'b0;
    w_pcs   = 1'b0;
    w_stall = 1'b0;
    w_tmo   = 1'b0;
    if (!reset) begin
      case (r_state)
        S_IDLE: begin
          if (w_mc) begin
            w_start = 1'b1;
            w_stall = 1'b1;
          end else begin
            w_pcw = 1'b1;
            w_rw  = bus.RegWriteIn;
            w_mw  = bus.MemWriteIn;
            w_pcs = bus.PCSrcIn;
          end
        end
        S_WAIT: w_stall = 1'b1;
        S_COMMIT: begin
          w_pcw = 1'b1;
          w_rw  = bus.RegWriteIn;
          w_mw  = bus.MemWriteIn;
          w_pcs = bus.PCSrcIn;
        end
`ifdef ALU_STALL_TIMEOUT_EN
        S_FAULT: begin
          w_stall = 1'b1;
          w_tmo   = 1'b1;
        end
`endif
        default: ;
      endcase
    end
  end

  assign bus.StartALU   = w_start;
  assign bus.PCWrite    = w_pcw;
  assign bus.RegWrite   = w_rw;
  assign bus.MemWrite   = w_mw;
  assign bus.PCSrc      = w_pcs;
  assign bus.Stall      = w_stall;
  assign bus.Timeout    = w_tmo;
  assign bus.BusyCycles = reset ? '0 : r_busy;
endmodule

// File: tb/tb_alu_stall_sequencer.sv
// Scoreboard bench for alu_stall_sequencer: each driven cycle pushes its
// expected outputs; a negedge monitor pops and compares them.
module tb_alu_stall_sequencer;
`ifdef ALU_STALL_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif
  localparam logic [3:0] ADD = 4'b0000;
  localparam logic [3:0] MUL = 4'b0101;
  localparam logic [3:0] DIV = 4'b0110;
  localparam logic [3:0] MOD = 4'b0111;

  typedef struct packed {
    logic       start, pcw, rw, mw, pcs, stall, tmo;
    logic [7:0] busy;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_cyc = 0;
  exp_t sb[$];
  exp_t e;

  alu_stall_sequencer_if #(.CNT_W(8)) bus ();

  alu_stall_sequencer #(.TIMEOUT_CYCLES(8), .CNT_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  function automatic exp_t E(input bit s, p, r, m, c, st, t, input int b);
    exp_t x;
    x.start = s; x.pcw = p; x.rw = r; x.mw = m; x.pcs = c;
    x.stall = st; x.tmo = t; x.busy = 8'(b);
    return x;
  endfunction

  // drive one cycle's inputs just after the edge and queue its expectation
  task automatic cyc(input bit rst, input logic [3:0] op, input bit rw, mw, pcs, fin,
                     input exp_t x);
    @(posedge clk);
    #1;
    reset          = rst;
    bus.ALUControl = op;
    bus.RegWriteIn = rw;
    bus.MemWriteIn = mw;
    bus.PCSrcIn    = pcs;
    bus.Finished   = fin;
    sb.push_back(x);
  endtask

  // outputs are combinational within the cycle; sample mid-cycle
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      e = sb.pop_front();
      n_cyc++;
      chk($sformatf("c%0d.StartALU", n_cyc), 32'(bus.StartALU), 32'(e.start));
      chk($sformatf("c%0d.PCWrite", n_cyc),  32'(bus.PCWrite),  32'(e.pcw));
      chk($sformatf("c%0d.RegWrite", n_cyc), 32'(bus.RegWrite), 32'(e.rw));
      chk($sformatf("c%0d.MemWrite", n_cyc), 32'(bus.MemWrite), 32'(e.mw));
      chk($sformatf("c%0d.PCSrc", n_cyc),    32'(bus.PCSrc),    32'(e.pcs));
      chk($sformatf("c%0d.Stall", n_cyc),    32'(bus.Stall),    32'(e.stall));
      chk($sformatf("c%0d.Timeout", n_cyc),  32'(bus.Timeout),  32'(e.tmo));
      chk($sformatf("c%0d.BusyCycles", n_cyc), 32'(bus.BusyCycles), 32'(e.busy));
    end
  end

  initial begin
    bus.ALUControl = ADD;
    bus.RegWriteIn = 1'b0;
    bus.MemWriteIn = 1'b0;
    bus.PCSrcIn    = 1'b0;
    bus.Finished   = 1'b0;

    // reset holds all outputs low even with a multi-cycle op presented
    cyc(1, MUL, 1, 0, 0, 0, E(0,0,0,0,0,0,0,0));
    // single-cycle pass-through, then Finished ignored in IDLE
    cyc(0, ADD, 1, 0, 1, 0, E(0,1,1,0,1,0,0,0));
    cyc(0, ADD, 0, 1, 0, 1, E(0,1,0,1,0,0,0,0));
    // MUL, Finished on 3rd WAIT cycle; opcode change during WAIT ignored
    cyc(0, MUL, 1, 0, 0, 0, E(1,0,0,0,0,1,0,0));
    cyc(0, ADD, 1, 1, 1, 0, E(0,0,0,0,0,1,0,0));
    cyc(0, ADD, 1, 1, 1, 0, E(0,0,0,0,0,1,0,0));
    cyc(0, ADD, 1, 1, 1, 1, E(0,0,0,0,0,1,0,0));
    cyc(0, ADD, 1, 0, 0, 0, E(0,1,1,0,0,0,0,3));
    // back-to-back: MUL (1 WAIT) with MUL still on ALUControl in COMMIT, then DIV (2 WAIT)
    cyc(0, MUL, 1, 0, 0, 0, E(1,0,0,0,0,1,0,3));
    cyc(0, MUL, 1, 0, 0, 1, E(0,0,0,0,0,1,0,3));
    cyc(0, MUL, 1, 0, 0, 0, E(0,1,1,0,0,0,0,1));
    cyc(0, DIV, 1, 0, 1, 0, E(1,0,0,0,0,1,0,1));
    cyc(0, DIV, 1, 0, 1, 0, E(0,0,0,0,0,1,0,1));
    cyc(0, DIV, 1, 0, 1, 1, E(0,0,0,0,0,1,0,1));
    cyc(0, DIV, 1, 0, 1, 0, E(0,1,1,0,1,0,0,2));
    // reset in 2nd WAIT cycle: no commit, next MUL issues from IDLE, BusyCycles cleared
    cyc(0, MOD, 1, 0, 0, 0, E(1,0,0,0,0,1,0,2));
    cyc(0, MOD, 1, 0, 0, 0, E(0,0,0,0,0,1,0,2));
    cyc(1, MOD, 1, 0, 0, 1, E(0,0,0,0,0,0,0,0));
    cyc(0, MUL, 1, 0, 0, 0, E(1,0,0,0,0,1,0,0));
    cyc(0, MUL, 0, 1, 0, 1, E(0,0,0,0,0,1,0,0));
    cyc(0, MUL, 0, 1, 0, 0, E(0,1,0,1,0,0,0,1));
    // Finished on the 8th WAIT cycle, coinciding with the watchdog limit
    cyc(0, MUL, 1, 0, 0, 0, E(1,0,0,0,0,1,0,1));
    for (int i = 1; i <= 7; i++) cyc(0, MUL, 1, 0, 0, 0, E(0,0,0,0,0,1,0,1));
    cyc(0, MUL, 1, 0, 0, 1, E(0,0,0,0,0,1,0,1));
    cyc(0, MUL, 1, 0, 0, 0, E(0,1,1,0,0,0,0,8));
    // Finished never arrives: Timeout after 8 WAIT cycles when enabled, Stall holds
    cyc(0, DIV, 0, 1, 1, 0, E(1,0,0,0,0,1,0,8));
    for (int w = 1; w <= 25; w++)
      cyc(0, DIV, 0, 1, 1, 0, E(0,0,0,0,0,1, TMO_EN && (w > 8), 8));
    // reset clears everything, normal operation resumes
    cyc(1, ADD, 1, 1, 1, 0, E(0,0,0,0,0,0,0,0));
    cyc(0, ADD, 1, 1, 1, 0, E(0,1,1,1,1,0,0,0));

    @(negedge clk);
    #1;
    chk("scoreboard_drain", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
